// File: rtl/nios_pio_out_ext.sv
// nios_pio_out_ext: Avalon-MM output PIO with configurable width/reset value,
// atomic SET/CLR/TOGGLE write ports and an optional timed-pulse engine.
// Optional feature macro: NIOS_PIO_PULSE_EN (pulse engine, PULSE_MASK,
// PULSE_LEN, STATUS count and PULSE register). Without it the block is a
// plain output port with atomic bit operations.
module nios_pio_out_ext #(
  parameter int unsigned           DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int unsigned           PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] out_next;
  // Bits of writedata above the port width are ignored by design.
  logic                  unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign out_port  = out_reg;

`ifdef NIOS_PIO_PULSE_EN

  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_LEN    = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_PULSE  = 3'd7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                     state_reg;
  state_t                     state_next;
  logic [DATA_WIDTH-1:0]      mask_reg;
  logic [DATA_WIDTH-1:0]      mask_next;
  logic [PULSE_CNT_WIDTH-1:0] len_reg;
  logic [PULSE_CNT_WIDTH-1:0] len_next;
  logic [PULSE_CNT_WIDTH-1:0] cnt_reg;
  logic [PULSE_CNT_WIDTH-1:0] cnt_next;
  logic [PULSE_CNT_WIDTH-1:0] eff_len;
  logic                       expire;

  assign pulse_busy = (state_reg == ST_ACTIVE);

  // State register: output, pulse set, programmed length, remaining count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      out_reg   <= RESET_VALUE;
      mask_reg  <= '0;
      len_reg   <= PULSE_CNT_WIDTH'(1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      mask_reg  <= mask_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: expiry restore first, then the bus write on top of it.
  always_comb begin
    eff_len    = (len_reg == '0) ? PULSE_CNT_WIDTH'(1) : len_reg;
    expire     = (state_reg == ST_ACTIVE) && (cnt_reg == PULSE_CNT_WIDTH'(1));
    out_next   = out_reg;
    mask_next  = mask_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    state_next = state_reg;

    if (expire) begin
      out_next  = (out_reg & ~mask_reg) | (RESET_VALUE & mask_reg);
      mask_next = '0;
    end else if ((state_reg == ST_ACTIVE) && (cnt_reg > PULSE_CNT_WIDTH'(1))) begin
      cnt_next = cnt_reg - PULSE_CNT_WIDTH'(1);
    end

    if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          out_next  = wd;
          mask_next = '0;
        end
        ADDR_SET: begin
          out_next  = out_next | wd;
          mask_next = mask_next & ~wd;
        end
        ADDR_CLR: begin
          out_next  = out_next & ~wd;
          mask_next = mask_next & ~wd;
        end
        ADDR_TOGGLE: begin
          out_next  = out_next ^ wd;
          mask_next = mask_next & ~wd;
        end
        ADDR_LEN: begin
          len_next = writedata[PULSE_CNT_WIDTH-1:0];
        end
        ADDR_PULSE: begin
          // A zero mask is a no-op; otherwise add bits and restart the count.
          if (wd != '0) begin
            out_next  = (out_next & ~wd) | (~RESET_VALUE & wd);
            mask_next = mask_next | wd;
            cnt_next  = eff_len;
          end
        end
        default: ;
      endcase
    end

    // An empty pulse set always means idle with a cleared count.
    if (mask_next == '0) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      state_next = ST_ACTIVE;
    end
  end

  // Combinational read mux; chipselect deliberately does not gate it.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(out_reg);
      ADDR_MASK:   readdata = 32'(mask_reg);
      ADDR_LEN:    readdata = 32'(len_reg);
      ADDR_STATUS: readdata = 32'({cnt_reg, pulse_busy});
      default:     readdata = '0;
    endcase
  end

`else

  // The pulse counter width has no consumer in the reduced build.
  logic [PULSE_CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;

  assign pulse_busy = 1'b0;

  // Output register only; no pulse state exists in this build.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= RESET_VALUE;
    end else begin
      out_reg <= out_next;
    end
  end

  // Next output value from DATA/SET/CLR/TOGGLE writes; other addresses ignored.
  always_comb begin
    out_next = out_reg;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   out_next = wd;
        ADDR_SET:    out_next = out_reg | wd;
        ADDR_CLR:    out_next = out_reg & ~wd;
        ADDR_TOGGLE: out_next = out_reg ^ wd;
        default:     out_next = out_reg;
      endcase
    end
  end

  // Only DATA reads back a value; everything else reads zero.
  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) begin
      readdata = 32'(out_reg);
    end
  end

`endif

endmodule

// File: tb/tb_nios_pio_out_ext.sv
// Testbench for nios_pio_out_ext: deadline-based behavioural model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_nios_pio_out_ext;

  localparam logic [7:0] RV = 8'h5A;
`ifdef NIOS_PIO_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  int checks = 0;
  int failures = 0;

  nios_pio_out_ext #(
    .DATA_WIDTH(8),
    .RESET_VALUE(RV),
    .PULSE_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .pulse_busy(pulse_busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The pulse is tracked as an absolute expiry edge number, not a counter.
  int         cyc = 0;
  logic [7:0] m_out = RV;
  logic [7:0] m_mask = 8'h00;
  logic [15:0] m_len = 16'd1;
  int         m_deadline = 0;

  always @(posedge clk or posedge reset) begin : model_update
    logic [7:0]  n_out;
    logic [7:0]  n_mask;
    logic [7:0]  wd8;
    logic [15:0] n_len;
    int          e;
    int          n_dl;
    if (reset) begin
      m_out      <= RV;
      m_mask     <= 8'h00;
      m_len      <= 16'd1;
      m_deadline <= 0;
    end else begin
      e      = cyc + 1;
      n_out  = m_out;
      n_mask = m_mask;
      n_len  = m_len;
      n_dl   = m_deadline;
      wd8    = writedata[7:0];
      if ((n_mask != 8'h00) && (e == n_dl)) begin
        for (int b = 0; b < 8; b++)
          if (n_mask[b]) n_out[b] = RV[b];
        n_mask = 8'h00;
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: begin n_out = wd8; n_mask = 8'h00; end
          3'd1: begin n_out = n_out | wd8;  n_mask = n_mask & ~wd8; end
          3'd2: begin n_out = n_out & ~wd8; n_mask = n_mask & ~wd8; end
          3'd3: begin n_out = n_out ^ wd8;  n_mask = n_mask & ~wd8; end
          3'd5: if (PULSE_EN) n_len = writedata[15:0];
          3'd7: if (PULSE_EN && (wd8 != 8'h00)) begin
            for (int b = 0; b < 8; b++)
              if (wd8[b]) n_out[b] = ~RV[b];
            n_mask = n_mask | wd8;
            n_dl   = e + ((m_len == 16'd0) ? 1 : int'(m_len));
          end
          default: ;
        endcase
      end
      cyc        <= e;
      m_out      <= n_out;
      m_mask     <= n_mask;
      m_len      <= n_len;
      m_deadline <= n_dl;
    end
  end

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [15:0] rem;
    logic        busy;
    busy = (m_mask != 8'h00);
    rem  = busy ? 16'(m_deadline - cyc) : 16'd0;
    case (a)
      3'd0: return {24'd0, m_out};
      3'd4: return PULSE_EN ? {24'd0, m_mask} : 32'd0;
      3'd5: return PULSE_EN ? {16'd0, m_len} : 32'd0;
      3'd6: return PULSE_EN ? {15'd0, rem, busy} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%08h expected=0x%08h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_out_port", {24'd0, out_port}, {24'd0, m_out});
    chk("cyc_pulse_busy", {31'd0, pulse_busy}, {31'd0, (m_mask != 8'h00)});
    chk("cyc_readdata", readdata, model_read(address));
  end

  // ---------------- stimulus helpers ----------------
  logic [2:0] addr_rot = 3'd0;
  int n0 = 0;
  int n1 = 0;
  int nb = 0;

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    $display("WR addr=%0d data=0x%08h out_port=0x%02h busy=%0b", a, d, out_port, pulse_busy);
  endtask

  task automatic idle();
    address  = addr_rot;
    addr_rot = addr_rot + 3'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n0 = 0;
    n1 = 0;
    nb = 0;
  endtask

  // Count cycles where bit0/bit1 sit away from their reset value.
  task automatic sample();
    logic [7:0] d;
    d = out_port ^ RV;
    if (d[0]) n0++;
    if (d[1]) n1++;
    if (pulse_busy) nb++;
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : driver
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_port", {24'd0, out_port}, 32'h0000005A);
    read_chk("reset_read_data", 3'd0, 32'h0000005A);
    chk("reset_busy", {31'd0, pulse_busy}, 32'd0);
    reset = 1'b0;
    idle();

    // Atomic bit operations.
    do_write(3'd0, 32'h0000000F);
    chk("data_0F", {24'd0, out_port}, 32'h0F);
    do_write(3'd1, 32'h00000030);
    chk("set_30", {24'd0, out_port}, 32'h3F);
    do_write(3'd2, 32'h00000003);
    chk("clr_03", {24'd0, out_port}, 32'h3C);
    do_write(3'd3, 32'hFFFFFF81);
    chk("toggle_81", {24'd0, out_port}, 32'hBD);
    read_chk("read_set_zero", 3'd1, 32'd0);
    read_chk("read_clr_zero", 3'd2, 32'd0);
    read_chk("read_tgl_zero", 3'd3, 32'd0);
    read_chk("read_data_BD", 3'd0, 32'h000000BD);

    // Write without chipselect is ignored.
    chipselect = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'hFF;
    @(posedge clk); #1;
    write_n = 1'b1; writedata = 32'd0;
    chk("no_cs_ignored", {24'd0, out_port}, 32'hBD);

    // 5-cycle pulse on bit0.
    do_write(3'd0, 32'h5A);
    do_write(3'd5, 32'd5);
    clear_counts();
    do_write(3'd7, 32'h01);
    sample();
    chk("pulse5_out", {24'd0, out_port}, PULSE_EN ? 32'h5B : 32'h5A);
    read_chk("pulse5_status", 3'd6, PULSE_EN ? 32'h0000000B : 32'd0);
    read_chk("pulse5_mask", 3'd4, PULSE_EN ? 32'h1 : 32'd0);
    repeat (8) begin idle(); sample(); end
    chk("pulse5_bit0_cycles", n0, PULSE_EN ? 32'd5 : 32'd0);
    chk("pulse5_busy_cycles", nb, PULSE_EN ? 32'd5 : 32'd0);
    chk("pulse5_restored", {24'd0, out_port}, 32'h5A);

    // Zero length behaves as one cycle.
    do_write(3'd5, 32'd0);
    read_chk("len_zero_read", 3'd5, 32'd0);
    clear_counts();
    do_write(3'd7, 32'h01);
    sample();
    repeat (3) begin idle(); sample(); end
    chk("pulse_len0_cycles", n0, PULSE_EN ? 32'd1 : 32'd0);

    // Extension: second pulse two cycles after the first.
    do_write(3'd5, 32'd4);
    clear_counts();
    do_write(3'd7, 32'h01);
    sample();
    idle(); sample();
    do_write(3'd7, 32'h02);
    sample();
    chk("extend_both_out", {24'd0, out_port}, PULSE_EN ? 32'h59 : 32'h5A);
    repeat (8) begin idle(); sample(); end
    chk("extend_bit0_cycles", n0, PULSE_EN ? 32'd6 : 32'd0);
    chk("extend_bit1_cycles", n1, PULSE_EN ? 32'd4 : 32'd0);
    chk("extend_busy_cycles", nb, PULSE_EN ? 32'd6 : 32'd0);

    // CLR removes a bit from a running pulse.
    do_write(3'd5, 32'd10);
    clear_counts();
    do_write(3'd7, 32'h03);
    sample();
    idle(); sample();
    idle(); sample();
    do_write(3'd2, 32'h01);
    sample();
    chk("clr_mid_bit0_low", {31'd0, out_port[0]}, 32'd0);
    read_chk("clr_mid_mask", 3'd4, PULSE_EN ? 32'h2 : 32'd0);
    repeat (12) begin idle(); sample(); end
    chk("clr_mid_bit0_cycles", n0, PULSE_EN ? 32'd3 : 32'd0);
    chk("clr_mid_bit1_cycles", n1, PULSE_EN ? 32'd10 : 32'd0);
    chk("clr_mid_busy_cycles", nb, PULSE_EN ? 32'd10 : 32'd0);
    chk("clr_mid_final", {24'd0, out_port}, 32'h5A);

    // DATA write cancels a running pulse.
    do_write(3'd7, 32'h03);
    idle();
    idle();
    do_write(3'd0, 32'hC3);
    chk("data_cancel_out", {24'd0, out_port}, 32'hC3);
    chk("data_cancel_busy", {31'd0, pulse_busy}, 32'd0);
    repeat (12) idle();
    chk("data_cancel_held", {24'd0, out_port}, 32'hC3);

    // Asynchronous reset in the middle of a pulse.
    do_write(3'd7, 32'h0C);
    chk("pre_reset_out", {24'd0, out_port}, PULSE_EN ? 32'hC7 : 32'hC3);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out", {24'd0, out_port}, 32'h5A);
    chk("async_reset_busy", {31'd0, pulse_busy}, 32'd0);
    read_chk("async_reset_len", 3'd5, PULSE_EN ? 32'd1 : 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Writes after reset still work.
    do_write(3'd3, 32'hFF);
    chk("post_reset_toggle", {24'd0, out_port}, 32'hA5);
    repeat (8) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
